mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 3, range 1..15: the number of consecutive DM grants allowed while IF waits.
REQ-002 The block SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port if_req  in  1  instruction-fetch read request.
REQ-005 The block SHALL have port if_addr  in  14  fetch word address.
REQ-006 The block SHALL have port if_gnt  out  1  fetch request accepted this cycle.
REQ-007 The block SHALL have port if_rvalid  out  1  fetch read data valid.
REQ-008 The block SHALL have port if_rdata  out  32  fetch read data.
REQ-009 The block SHALL have port dm_req  in  1  data-memory request.
REQ-010 The block SHALL have port dm_web  in  4  active-low byte write enables; 4'b1111 means read.
REQ-011 The block SHALL have port dm_addr  in  14  data word address.
REQ-012 The block SHALL have port dm_wdata  in  32  store data.
REQ-013 The block SHALL have port dm_gnt  out  1  data request accepted this cycle.
REQ-014 The block SHALL have port dm_rvalid  out  1  load data valid.
REQ-015 The block SHALL have port dm_rdata  out  32  load data.
REQ-016 The block SHALL have ports sram_cs, sram_oe (out 1), sram_web (out 4), sram_a (out 14), sram_di (out 32): the shared SRAM port.
REQ-017 The block SHALL have port sram_do  in  32  SRAM read data, valid in the cycle after the access.

Function
REQ-018 Grant SHALL be combinational in the request cycle; at most one of if_gnt and dm_gnt SHALL be high in any cycle.
REQ-019 Default priority SHALL be DM over IF; when only one port requests, that port SHALL be granted.
REQ-020 The granted port SHALL drive the SRAM in the same cycle: sram_cs=1, sram_a=addr, sram_web=dm_web (IF: 4'b1111), sram_di=dm_wdata (IF: 0), and sram_oe=1 for reads only.
REQ-021 With no grant, the block SHALL drive sram_cs=0, sram_oe=0, sram_web=4'b1111, sram_a=0 and sram_di=0.
REQ-022 A registered response owner {NONE, IF, DM} SHALL record each read grant; a write grant or no grant SHALL record NONE.
REQ-023 In the cycle after a read grant, the owner's rvalid SHALL be 1 for exactly one cycle, and its rdata SHALL equal sram_do. Read latency is 1.
REQ-024 Each port SHALL hold its rdata in a register and keep it stable until that port's next rvalid; writes SHALL never assert rvalid or change rdata.
REQ-025 Back-to-back grants SHALL be fully pipelined at 1 access per cycle, with no bubble between ports.
REQ-026 A starvation counter (4 bits) SHALL increment on each cycle where dm_gnt=1 and if_req=1, and SHALL clear when if_gnt=1 or when if_req=0.
REQ-027 When the counter equals STARVE_LIMIT and both ports request, IF SHALL be granted and the counter SHALL clear.

Reset
REQ-028 While rst=0 at a clock edge, the block SHALL clear the response owner to NONE, the counter to 0, if_rvalid and dm_rvalid to 0, and if_rdata and dm_rdata to 0.
REQ-029 While rst=0, if_gnt and dm_gnt SHALL be 0 and the SRAM port SHALL be idle per REQ-021.
REQ-030 A read granted in the cycle before reset is asserted SHALL produce no rvalid.

Configuration
REQ-031 With MEM_ARB_FAIRNESS_EN defined, REQ-026 and REQ-027 SHALL apply.
REQ-032 Without MEM_ARB_FAIRNESS_EN, the counter SHALL be absent and strict DM priority SHALL apply; IF can starve indefinitely.

Verification
REQ-033 The bench SHALL cover a single IF read: if_req=1, if_addr=0x0010 with SRAM word 0x0010=0x00A00093 -> if_gnt=1 and sram_a=0x0010 in cycle N, then if_rvalid=1 and if_rdata=0x00A00093 in cycle N+1.
REQ-034 The bench SHALL cover a collision: if_req and dm_req both 1, dm_web=4'b1111, dm_addr=0x0100 -> dm_gnt=1, if_gnt=0, then dm_rvalid=1 in the next cycle and if_rvalid=0.
REQ-035 The bench SHALL cover a store: dm_web=4'b1100, dm_wdata=0xDEADBEEF, dm_addr=0x0004 -> sram_web=4'b1100, sram_oe=0, and no dm_rvalid; a later read of 0x0004 returns 0xDEADBEEF on the enabled bytes.
REQ-036 The bench SHALL cover fairness (macro defined, STARVE_LIMIT=3): both ports request continuously -> grant sequence DM,DM,DM,IF repeating; with the macro undefined -> DM every cycle.
REQ-037 The bench SHALL cover reset mid-operation: an IF read granted in cycle N and rst=0 at edge N+1 -> if_rvalid=0, if_rdata=0, counter=0, and both grants 0 while rst=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data memory) arbiter onto one single-port SRAM, 1-cycle read latency.
// DM has priority; define MEM_ARB_FAIRNESS_EN to force an IF grant after STARVE_LIMIT consecutive DM wins.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [13:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic [3:0]  dm_web,
  input  logic [13:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        sram_cs,
  output logic        sram_oe,
  output logic [3:0]  sram_web,
  output logic [13:0] sram_a,
  output logic [31:0] sram_di,
  input  logic [31:0] sram_do
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  owner_t      owner_q, owner_d;
  logic        force_if;
  logic        dm_rd;
  logic [31:0] if_rdata_q, dm_rdata_q;

  assign dm_rd = (dm_web == 4'b1111);

`ifdef MEM_ARB_FAIRNESS_EN
  logic [3:0] starve_q;

  assign force_if = if_req && dm_req && (starve_q == 4'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q <= 4'd0;
    end else if (if_gnt || !if_req) begin
      starve_q <= 4'd0;
    end else if (dm_gnt) begin
      starve_q <= starve_q + 4'd1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    sram_cs  = 1'b0;
    sram_oe  = 1'b0;
    sram_web = 4'b1111;
    sram_a   = 14'd0;
    sram_di  = 32'd0;
    owner_d  = OWN_NONE;
    if (rst) begin
      if (dm_req && !force_if) begin
        dm_gnt   = 1'b1;
        sram_cs  = 1'b1;
        sram_oe  = dm_rd;
        sram_web = dm_web;
        sram_a   = dm_addr;
        sram_di  = dm_wdata;
        owner_d  = dm_rd ? OWN_DM : OWN_NONE;
      end else if (if_req) begin
        if_gnt  = 1'b1;
        sram_cs = 1'b1;
        sram_oe = 1'b1;
        sram_a  = if_addr;
        owner_d = OWN_IF;
      end
    end
  end

  // rvalid is gated by rst so a read granted just before reset never completes
  assign if_rvalid = rst && (owner_q == OWN_IF);
  assign dm_rvalid = rst && (owner_q == OWN_DM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
    end else begin
      if (if_rvalid) if_rdata_q <= sram_do;
      if (dm_rvalid) dm_rdata_q <= sram_do;
    end
  end

  assign if_rdata = if_rvalid ? sram_do : if_rdata_q;
  assign dm_rdata = dm_rvalid ? sram_do : dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural byte-writable SRAM.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req;
  logic [13:0] if_addr, dm_addr;
  logic [3:0]  dm_web;
  logic [31:0] dm_wdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata;
  logic        sram_cs, sram_oe;
  logic [3:0]  sram_web;
  logic [13:0] sram_a;
  logic [31:0] sram_di;
  logic [31:0] sram_do = 32'd0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        gi, gd, cs, oe;
    logic [3:0]  web;
    logic [13:0] a;
    logic [31:0] di;
  } gexp_t;
  typedef struct packed {
    logic        dm;
    logic [31:0] dat;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  logic [31:0] hold_if = 32'd0;
  logic [31:0] hold_dm = 32'd0;

  logic [31:0] mem [0:16383];

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_web(dm_web), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
  );

  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_oe) sram_do <= mem[sram_a];
      for (int b = 0; b < 4; b++)
        if (!sram_web[b]) mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
    end
  end

  // g: 0 = no grant, 1 = IF, 2 = DM; resp/rdat: expected read data next cycle
  task automatic step(input logic r, input logic ir, input logic [13:0] ia,
                      input logic dr, input logic [3:0] dw, input logic [13:0] da,
                      input logic [31:0] dd, input int g, input logic resp,
                      input logic [31:0] rdat);
    gexp_t e;
    rexp_t x;
    @(posedge clk);
    #1;
    rst = r; if_req = ir; if_addr = ia; dm_req = dr; dm_web = dw; dm_addr = da; dm_wdata = dd;
    e = '{gi: 1'b0, gd: 1'b0, cs: 1'b0, oe: 1'b0, web: 4'hF, a: 14'd0, di: 32'd0};
    if (g == 1) e = '{gi: 1'b1, gd: 1'b0, cs: 1'b1, oe: 1'b1, web: 4'hF, a: ia, di: 32'd0};
    if (g == 2) e = '{gi: 1'b0, gd: 1'b1, cs: 1'b1, oe: (dw == 4'hF), web: dw, a: da, di: dd};
    gq.push_back(e);
    if (resp) begin
      x.dm = (g == 2);
      x.dat = rdat;
      rq.push_back(x);
    end
  endtask

  task automatic idle(input logic r);
    step(r, 1'b0, 14'd0, 1'b0, 4'hF, 14'd0, 32'd0, 0, 1'b0, 32'd0);
  endtask

  always @(negedge clk) begin
    gexp_t e;
    rexp_t x;
    if (gq.size() > 0) begin
      e = gq.pop_front();
      checks++;
      if ({if_gnt, dm_gnt, sram_cs, sram_oe, sram_web, sram_a, sram_di} !== e) begin
        errors++;
        $display("FAIL grant_sram got gi=%b gd=%b cs=%b oe=%b web=%h a=%h di=%h want gi=%b gd=%b cs=%b oe=%b web=%h a=%h di=%h",
                 if_gnt, dm_gnt, sram_cs, sram_oe, sram_web, sram_a, sram_di,
                 e.gi, e.gd, e.cs, e.oe, e.web, e.a, e.di);
      end
    end
    if (if_rvalid || dm_rvalid) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid got if_rvalid=%b dm_rvalid=%b want none", if_rvalid, dm_rvalid);
      end else begin
        x = rq.pop_front();
        if ((if_rvalid && dm_rvalid) || (x.dm != dm_rvalid) ||
            ((x.dm ? dm_rdata : if_rdata) !== x.dat)) begin
          errors++;
          $display("FAIL read_resp got if_rvalid=%b dm_rvalid=%b if_rdata=%h dm_rdata=%h want port_dm=%b data=%h",
                   if_rvalid, dm_rvalid, if_rdata, dm_rdata, x.dm, x.dat);
        end
        if (x.dm) hold_dm = x.dat;
        else      hold_if = x.dat;
      end
    end
    if (!if_rvalid) begin
      checks++;
      if (if_rdata !== hold_if) begin
        errors++;
        $display("FAIL if_rdata_hold got %h want %h", if_rdata, hold_if);
      end
    end
    if (!dm_rvalid) begin
      checks++;
      if (dm_rdata !== hold_dm) begin
        errors++;
        $display("FAIL dm_rdata_hold got %h want %h", dm_rdata, hold_dm);
      end
    end
    if (!rst) begin
      hold_if = 32'd0;
      hold_dm = 32'd0;
    end
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
    mem[14'h0010] = 32'h00A00093;
    mem[14'h0100] = 32'h12345678;
    mem[14'h0004] = 32'h11223344;
    mem[14'h0020] = 32'hCAFEF00D;
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; if_addr = 14'd0; dm_addr = 14'd0;
    dm_web = 4'hF; dm_wdata = 32'd0;

    // reset with requests pending: no grants, idle SRAM port
    step(1'b0, 1'b1, 14'h0010, 1'b1, 4'hF, 14'h0100, 32'd0, 0, 1'b0, 32'd0);
    idle(1'b0);
    idle(1'b1);

    // single IF read
    step(1'b1, 1'b1, 14'h0010, 1'b0, 4'hF, 14'd0, 32'd0, 1, 1'b1, 32'h00A00093);
    idle(1'b1);

    // collision: DM read wins
    step(1'b1, 1'b1, 14'h0020, 1'b1, 4'hF, 14'h0100, 32'd0, 2, 1'b1, 32'h12345678);
    idle(1'b1);

    // partial store, then read back
    step(1'b1, 1'b0, 14'd0, 1'b1, 4'b1100, 14'h0004, 32'hDEADBEEF, 2, 1'b0, 32'd0);
    idle(1'b1);
    step(1'b1, 1'b0, 14'd0, 1'b1, 4'hF, 14'h0004, 32'd0, 2, 1'b1, 32'h1122BEEF);

    // back-to-back alternating ports, no bubbles
    step(1'b1, 1'b1, 14'h0020, 1'b0, 4'hF, 14'd0, 32'd0, 1, 1'b1, 32'hCAFEF00D);
    step(1'b1, 1'b0, 14'd0, 1'b1, 4'hF, 14'h0010, 32'd0, 2, 1'b1, 32'h00A00093);
    step(1'b1, 1'b1, 14'h0100, 1'b0, 4'hF, 14'd0, 32'd0, 1, 1'b1, 32'h12345678);
    idle(1'b1);

    // continuous contention
    for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_FAIRNESS_EN
      if (i % 4 == 3)
        step(1'b1, 1'b1, 14'h0010, 1'b1, 4'hF, 14'h0100, 32'd0, 1, 1'b1, 32'h00A00093);
      else
`endif
        step(1'b1, 1'b1, 14'h0010, 1'b1, 4'hF, 14'h0100, 32'd0, 2, 1'b1, 32'h12345678);
    end
    idle(1'b1);

    // build up starvation count, reset with a DM read in flight
    step(1'b1, 1'b1, 14'h0020, 1'b1, 4'hF, 14'h0004, 32'd0, 2, 1'b1, 32'h1122BEEF);
    step(1'b1, 1'b1, 14'h0020, 1'b1, 4'hF, 14'h0010, 32'd0, 2, 1'b0, 32'd0);
    step(1'b0, 1'b1, 14'h0020, 1'b1, 4'hF, 14'h0010, 32'd0, 0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FAIRNESS_EN
      if (i == 3)
        step(1'b1, 1'b1, 14'h0020, 1'b1, 4'hF, 14'h0004, 32'd0, 1, 1'b1, 32'hCAFEF00D);
      else
`endif
        step(1'b1, 1'b1, 14'h0020, 1'b1, 4'hF, 14'h0004, 32'd0, 2, 1'b1, 32'h1122BEEF);
    end
    idle(1'b1);

    // IF read granted, reset asserted next cycle: no rvalid, rdata cleared
    step(1'b1, 1'b1, 14'h0100, 1'b0, 4'hF, 14'd0, 32'd0, 1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 14'h0010, 1'b0, 4'hF, 14'd0, 32'd0, 0, 1'b0, 32'd0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    @(posedge clk);
    #1;
    checks++;
    if (rq.size() != 0 || gq.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations got resp=%0d grant=%0d want 0 0", rq.size(), gq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
